shift_exec_stage: RTL and testbench
===================================

// Module: shift_exec_stage
// PURPOSE
//   Pipelined execute-stage wrapper for the barrel shifters (sll, plus srl/sra siblings).
//   Registers operands, selects shift type, registers result.
//   Valid/ready on both sides; sits between decode/issue and writeback.
//   Sustains one shift per cycle; tolerates downstream stalls without data loss.
// PARAMETERS
//   N      32  data width; power of two >= 8; shamt width = $clog2(N)
//   TAG_W   5  width of sideband tag (e.g. rd index) carried alongside each op
// PORTS
//   clk        in   1         rising-edge clock
//   rst_n      in   1         asynchronous active-low reset
//   in_valid   in   1         upstream has an op
//   in_ready   out  1         stage can accept an op this cycle
//   in_op      in   2         00 SLL, 01 SRL, 10 SRA, 11 PASS
//   in_data    in   N         operand to shift
//   in_shamt   in   $clog2(N) shift amount
//   in_tag     in   TAG_W     sideband, returned unchanged with result
//   out_valid  out  1         result available
//   out_ready  in   1         downstream accepts result
//   out_data   out  N         shifted result
//   out_tag    out  TAG_W     tag of the op producing out_data
//   op_count   out  32        completed-op counter (SHIFT_PERF_CNT_EN only)
// BEHAVIOUR
//   - Two register stages: A (op, data, shamt, tag) and B (result, tag); each has its own valid bit.
//   - Transfer occurs on valid && ready at a clock edge; latency 2 cycles from input handshake to out_valid.
//   - Stage B: b_ready = !b_valid || out_ready.
//   - Stage A: a_ready = !a_valid || b_ready.
//   - in_ready = a_ready; combinational from out_ready through both stages, no registered bubble.
//   - Full pipe with out_ready=1: one accept and one emit every cycle, throughput 1/cycle.
//   - Stall (out_valid && !out_ready): out_data/out_tag held stable; a_valid held.
//     in_ready=0 once both stages are valid.
//   - Shift between A and B is combinational:
//       SLL = data << shamt, zero fill.
//       SRL = data >> shamt, zero fill.
//       SRA = arithmetic right, fill with data[N-1].
//       PASS = data unchanged.
//   - shamt is an unsigned $clog2(N)-bit value. shamt=0 returns data unchanged for every op.
//     Maximum shamt is N-1; no overshift case exists.
//   - Tag travels with its op; ops complete strictly in order.
//   - Reset (async assert): a_valid=0, b_valid=0, out_valid=0, out_data=0, out_tag=0, op_count=0.
//     in_ready=1 during and after reset.
//   - Reset mid-operation: all in-flight ops discarded, not emitted.
//   - Reset is released synchronously to clk by the system.
//   - No internal state other than the stage registers and op_count.
// CONFIGURATION
//   SHIFT_PERF_CNT_EN defined:
//     op_count increments by 1 on every out_valid && out_ready edge.
//     Wraps 0xFFFFFFFF -> 0.
//   SHIFT_PERF_CNT_EN undefined:
//     op_count port present but tied to 0; no counter flops.
// TESTING
//   1. Reset then SLL data=0x0000_0001 shamt=31, out_ready=1
//      -> out_data=0x8000_0000 exactly 2 cycles after accept.
//   2. SRA data=0x8000_00F0 shamt=4 -> 0xF800_000F.
//      SRL same operands -> 0x0800_000F.
//      PASS -> 0x8000_00F0.
//      shamt=0 on all ops -> 0x8000_00F0.
//   3. Back-to-back 8 ops (tags 0..7) with out_ready=1
//      -> 8 results on 8 consecutive cycles, tags 0..7 in order.
//   4. Hold out_ready=0 while streaming -> in_ready drops after 2 accepts; out_data/out_tag stable.
//      Release out_ready -> no loss, no duplication, order preserved.
//   5. Assert rst_n low with both stages valid -> out_valid=0 immediately (async).
//      After release, no stale result is emitted.
//   6. With SHIFT_PERF_CNT_EN: preload-free run of 5 handshakes -> op_count=5.
//      Stalled cycles do not count.
//      Without the macro -> op_count stays 0.

Source files
------------

// File: rtl/shift_exec_stage.sv
// Two-stage valid/ready execute wrapper for SLL/SRL/SRA/PASS shifts with a sideband tag.
// Optional completed-op counter enabled by defining SHIFT_PERF_CNT_EN.
module shift_exec_stage #(
    parameter int unsigned N     = 32,
    parameter int unsigned TAG_W = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [1:0]           in_op,
    input  logic [N-1:0]         in_data,
    input  logic [$clog2(N)-1:0] in_shamt,
    input  logic [TAG_W-1:0]     in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [N-1:0]         out_data,
    output logic [TAG_W-1:0]     out_tag,
    output logic [31:0]          op_count
);

    localparam int unsigned SW = $clog2(N);

    typedef enum logic [1:0] {
        OP_SLL  = 2'b00,
        OP_SRL  = 2'b01,
        OP_SRA  = 2'b10,
        OP_PASS = 2'b11
    } op_e;

    logic             a_valid;
    op_e              a_op;
    logic [N-1:0]     a_data;
    logic [SW-1:0]    a_shamt;
    logic [TAG_W-1:0] a_tag;

    logic             b_valid;
    logic [N-1:0]     b_data;
    logic [TAG_W-1:0] b_tag;

    logic             a_ready;
    logic             b_ready;
    logic [N-1:0]     shift_res;

    // Backpressure ripples combinationally from out_ready so a full pipe still moves every cycle.
    assign b_ready  = !b_valid || out_ready;
    assign a_ready  = !a_valid || b_ready;
    assign in_ready = a_ready;

    assign out_valid = b_valid;
    assign out_data  = b_data;
    assign out_tag   = b_tag;

    always_comb begin
        shift_res = a_data;
        case (a_op)
            OP_SLL:  shift_res = a_data << a_shamt;
            OP_SRL:  shift_res = a_data >> a_shamt;
            OP_SRA:  shift_res = N'($signed(a_data) >>> a_shamt);
            OP_PASS: shift_res = a_data;
            default: shift_res = a_data;
        endcase
    end

    // Stage A: operand register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_valid <= 1'b0;
            a_op    <= OP_SLL;
            a_data  <= '0;
            a_shamt <= '0;
            a_tag   <= '0;
        end else if (a_ready) begin
            a_valid <= in_valid;
            if (in_valid) begin
                a_op    <= op_e'(in_op);
                a_data  <= in_data;
                a_shamt <= in_shamt;
                a_tag   <= in_tag;
            end
        end
    end

    // Stage B: result register; holds contents while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b_valid <= 1'b0;
            b_data  <= '0;
            b_tag   <= '0;
        end else if (b_ready) begin
            b_valid <= a_valid;
            if (a_valid) begin
                b_data <= shift_res;
                b_tag  <= a_tag;
            end
        end
    end

`ifdef SHIFT_PERF_CNT_EN
    // Counts output handshakes; wraps naturally at 2^32.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_count <= 32'd0;
        end else if (b_valid && out_ready) begin
            op_count <= op_count + 32'd1;
        end
    end
`else
    assign op_count = 32'd0;
`endif

endmodule

// File: tb/tb_shift_exec_stage.sv
// Scoreboard bench for shift_exec_stage: expected results queued at accept, compared at emit.
module tb_shift_exec_stage;

    localparam int unsigned N     = 32;
    localparam int unsigned TAG_W = 5;
    localparam int unsigned SW    = 5;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [1:0]       in_op = 2'b00;
    logic [N-1:0]     in_data = '0;
    logic [SW-1:0]    in_shamt = '0;
    logic [TAG_W-1:0] in_tag = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [N-1:0]     out_data;
    logic [TAG_W-1:0] out_tag;
    logic [31:0]      op_count;

    int errors = 0;
    int checks = 0;

    logic [N-1:0]     exp_data[$];
    logic [TAG_W-1:0] exp_tag[$];
    logic [N-1:0]     mon_ed;
    logic [TAG_W-1:0] mon_et;
    int cyc = 0;
    int last_emit = -10;
    int run_len = 0;
    int max_run = 0;
    bit rand_ready = 1'b0;

    shift_exec_stage #(.N(N), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_data(in_data), .in_shamt(in_shamt), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_tag(out_tag), .op_count(op_count)
    );

    always #5 clk = ~clk;

    // Bit-serial reference shifter.
    function automatic logic [N-1:0] model(input logic [1:0] op, input logic [N-1:0] d,
                                           input logic [SW-1:0] sh);
        logic [N-1:0] r;
        r = d;
        for (int i = 0; i < int'(sh); i++) begin
            case (op)
                2'b00:   r = {r[N-2:0], 1'b0};
                2'b01:   r = {1'b0, r[N-1:1]};
                2'b10:   r = {r[N-1], r[N-1:1]};
                default: r = r;
            endcase
        end
        return r;
    endfunction

    // Output monitor: samples just before each rising edge.
    always begin
        @(negedge clk);
        #4;
        cyc++;
        if (rst_n && out_valid && out_ready) begin
            checks++;
            if (exp_data.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output: got data=%h tag=%0d, required none pending",
                         out_data, out_tag);
            end else begin
                mon_ed = exp_data.pop_front();
                mon_et = exp_tag.pop_front();
                if (out_data !== mon_ed || out_tag !== mon_et)begin
                    errors++;
                    $display("FAIL scoreboard: got data=%h tag=%0d, required data=%h tag=%0d",
                             out_data, out_tag, mon_ed, mon_et);
                end
            end
            run_len   = (cyc == last_emit + 1) ? run_len + 1 : 1;
            last_emit = cyc;
            if (run_len > max_run) max_run = run_len;
        end
    end

    task automatic send(input logic [1:0] op, input logic [N-1:0] d, input logic [SW-1:0] sh,
                        input logic [TAG_W-1:0] tag, input logic [N-1:0] exp, output int waits);
        waits = 0;
        @(negedge clk);
        if (rand_ready) out_ready = 1'($urandom_range(0, 1));
        in_valid = 1'b1; in_op = op; in_data = d; in_shamt = sh; in_tag = tag;
        #4;
        while (!in_ready) begin
            if (waits >= 50) begin
                checks++; errors++;
                $display("FAIL send_timeout: in_ready=%b after %0d cycles, required 1", in_ready, waits);
                break;
            end
            waits++;
            @(negedge clk);
            if (rand_ready) out_ready = 1'($urandom_range(0, 1));
            #4;
        end
        if (in_ready) begin
            exp_data.push_back(exp);
            exp_tag.push_back(tag);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        @(negedge clk);
        rand_ready = 1'b0;
        out_ready  = 1'b1;
        in_valid   = 1'b0;
        while (exp_data.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        checks++;
        if (exp_data.size() != 0) begin
            errors++;
            $display("FAIL drain_%s: pending=%0d, required 0", name, exp_data.size());
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        in_valid = 1'b0;
        exp_data.delete();
        exp_tag.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if (out_valid !== 1'b0 || out_data !== '0 || out_tag !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b d=%h t=%0d, required 0 0 0", out_valid, out_data, out_tag);
        end
        checks++;
        if (in_ready !== 1'b1 || op_count !== 32'd0) begin
            errors++;
            $display("FAIL reset_ready_cnt: got rdy=%b cnt=%0d, required 1 0", in_ready, op_count);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL post_reset: got v=%b rdy=%b, required 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_sll_latency();
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b1; in_op = 2'b00; in_data = 32'h0000_0001; in_shamt = 5'd31; in_tag = 5'd3;
        #4;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL sll_accept: in_ready=%b, required 1", in_ready);
        end
        exp_data.push_back(32'h8000_0000);
        exp_tag.push_back(5'd3);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL sll_latency_early: out_valid=%b one cycle after accept, required 0", out_valid);
        end
        @(negedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'h8000_0000 || out_tag !== 5'd3) begin
            errors++;
            $display("FAIL sll_latency: got v=%b d=%h t=%0d, required 1 80000000 3", out_valid, out_data, out_tag);
        end
        drain("sll");
    endtask

    task automatic test_shift_ops();
        logic [1:0]    ops [8] = '{2'b10, 2'b01, 2'b11, 2'b00, 2'b00, 2'b01, 2'b10, 2'b11};
        logic [SW-1:0] shs [8] = '{5'd4, 5'd4, 5'd4, 5'd4, 5'd0, 5'd0, 5'd0, 5'd0};
        logic [N-1:0]  exps[8] = '{32'hF800_000F, 32'h0800_000F, 32'h8000_00F0, 32'h0000_0F00,
                                   32'h8000_00F0, 32'h8000_00F0, 32'h8000_00F0, 32'h8000_00F0};
        int w;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++)
            send(ops[i], 32'h8000_00F0, shs[i], TAG_W'(i + 8), exps[i], w);
        drain("shift_ops");
    endtask

    task automatic test_back_to_back();
        int w;
        int total_waits;
        logic [N-1:0] d;
        total_waits = 0;
        max_run = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            d = 32'hA5C3_0F81 ^ (32'h0101_0101 * 32'(i));
            send(2'(i), d, SW'(3 * i + 1), TAG_W'(i), model(2'(i), d, SW'(3 * i + 1)), w);
            total_waits += w;
        end
        drain("b2b");
        checks++;
        if (total_waits != 0) begin
            errors++;
            $display("FAIL b2b_accept: stall cycles=%0d, required 0", total_waits);
        end
        checks++;
        if (max_run != 8) begin
            errors++;
            $display("FAIL b2b_emit_run: consecutive emits=%0d, required 8", max_run);
        end
    endtask

    task automatic test_stall();
        int w;
        logic [N-1:0] e1;
        e1 = model(2'b10, 32'hC000_1234, 5'd7);
        out_ready = 1'b0;
        send(2'b10, 32'hC000_1234, 5'd7, 5'd20, e1, w);
        send(2'b00, 32'h0000_FFFF, 5'd8, 5'd21, model(2'b00, 32'h0000_FFFF, 5'd8), w);
        @(negedge clk);
        in_valid = 1'b1; in_op = 2'b01; in_data = 32'hFFFF_0000; in_shamt = 5'd12; in_tag = 5'd22;
        for (int k = 0; k < 4; k++) begin
            #4;
            checks++;
            if (in_ready !== 1'b0) begin
                errors++;
                $display("FAIL stall_in_ready: cycle %0d got %b, required 0", k, in_ready);
            end
            checks++;
            if (out_valid !== 1'b1 || out_data !== e1 || out_tag !== 5'd20) begin
                errors++;
                $display("FAIL stall_hold: cycle %0d got v=%b d=%h t=%0d, required 1 %h 20",
                         k, out_valid, out_data, out_tag, e1);
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        #4;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL stall_release: in_ready=%b, required 1", in_ready);
        end
        exp_data.push_back(model(2'b01, 32'hFFFF_0000, 5'd12));
        exp_tag.push_back(5'd22);
        @(posedge clk);
        #1 in_valid = 1'b0;
        send(2'b11, 32'h1357_9BDF, 5'd3, 5'd23, 32'h1357_9BDF, w);
        send(2'b10, 32'h7000_0000, 5'd30, 5'd24, 32'h0000_0001, w);
        drain("stall");
    endtask

    task automatic test_reset_flush();
        int w;
        out_ready = 1'b0;
        send(2'b00, 32'h1111_1111, 5'd1, 5'd1, model(2'b00, 32'h1111_1111, 5'd1), w);
        send(2'b01, 32'h2222_2222, 5'd2, 5'd2, model(2'b01, 32'h2222_2222, 5'd2), w);
        @(negedge clk);
        #2 rst_n = 1'b0;
        exp_data.delete();
        exp_tag.delete();
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== '0 || out_tag !== '0) begin
            errors++;
            $display("FAIL async_reset: got v=%b d=%h t=%0d, required 0 0 0", out_valid, out_data, out_tag);
        end
        checks++;
        if (in_ready !== 1'b1 || op_count !== 32'd0) begin
            errors++;
            $display("FAIL async_reset_rdy: got rdy=%b cnt=%0d, required 1 0", in_ready, op_count);
        end
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #4;
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL stale_result: cycle %0d out_valid=%b d=%h, required 0", k, out_valid, out_data);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_perf();
        int w;
        logic [31:0] exp_cnt;
`ifdef SHIFT_PERF_CNT_EN
        exp_cnt = 32'd5;
`else
        exp_cnt = 32'd0;
`endif
        do_reset();
        out_ready = 1'b0;
        send(2'b00, 32'h0000_0003, 5'd4, 5'd5, 32'h0000_0030, w);
        send(2'b01, 32'h0000_0300, 5'd4, 5'd6, 32'h0000_0030, w);
        repeat (3) @(negedge clk);
        #4;
        checks++;
        if (op_count !== 32'd0) begin
            errors++;
            $display("FAIL perf_stalled: op_count=%0d, required 0", op_count);
        end
        out_ready = 1'b1;
        send(2'b10, 32'h8000_0000, 5'd31, 5'd7, 32'hFFFF_FFFF, w);
        send(2'b11, 32'hDEAD_BEEF, 5'd9, 5'd8, 32'hDEAD_BEEF, w);
        send(2'b00, 32'hFFFF_FFFF, 5'd16, 5'd9, 32'hFFFF_0000, w);
        drain("perf");
        #1;
        checks++;
        if (op_count !== exp_cnt) begin
            errors++;
            $display("FAIL perf_count: op_count=%0d, required %0d", op_count, exp_cnt);
        end
    endtask

    task automatic test_random();
        int w;
        logic [1:0]       op;
        logic [N-1:0]     d;
        logic [SW-1:0]    sh;
        rand_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            op = 2'($urandom_range(0, 3));
            d  = $urandom;
            sh = SW'($urandom_range(0, 31));
            send(op, d, sh, TAG_W'(i), model(op, d, sh), w);
        end
        drain("random");
    endtask

    initial begin
        test_reset();
        test_sll_latency();
        test_shift_ops();
        test_back_to_back();
        test_stall();
        test_reset_flush();
        test_perf();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
